measurement_scheduler: RTL
==========================

// Module: measurement_scheduler
// PURPOSE
//  Sequences the measurement/display datapath: on each periodic tick it requests an ADC sample,
//  starts the binary->BCD conversion when needed, then pulses the display register write enable.
//  Sits between the ADC data block, the binary_bcd converter and the 16-bit display register.
//  Replaces the manual button write with timed auto-refresh; the debounced button toggles HOLD.
// PARAMETERS
//  TICK_DIV  5_000_000  clk cycles per refresh tick (10 Hz at 50 MHz); legal range >= 8
//  TIMEOUT   1023       max cycles waited for adc_valid or conv_done before abort
// PORTS
//  clk          in   1  system clock
//  reset_n      in   1  asynchronous active-low reset
//  enable       in   1  1 = scheduler runs; 0 = prescaler frozen, no new cycles
//  hold_toggle  in   1  single-cycle pulse from debouncer; toggles hold
//  mode         in   2  synchronized SW[9:8]; mode[1]=1 -> BCD path, 0 -> hex path
//  adc_valid    in   1  ADC sample ready (level or pulse)
//  conv_done    in   1  binary_bcd result stable (single-cycle pulse)
//  adc_req      out  1  level: request new sample
//  conv_start   out  1  single-cycle pulse: start BCD conversion
//  reg_we       out  1  single-cycle pulse: load display register
//  hold         out  1  1 = display frozen
//  busy         out  1  1 whenever FSM is not IDLE
//  timeout_err  out  1  sticky; set on any handshake timeout, cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, prescaler 0, wait counter 0, latched mode 0.
//  - Prescaler counts 0..TICK_DIV-1 while enable=1; tick = 1 cycle when count==TICK_DIV-1.
//  - FSM states: IDLE, REQ_ADC, START_CONV, WAIT_CONV, WRITE.
//  - IDLE: on tick with hold=0 -> REQ_ADC; mode latched at this transition, held for whole cycle.
//  - REQ_ADC: adc_req=1; adc_valid=1 -> START_CONV if latched mode[1]=1, else WRITE.
//  - START_CONV: conv_start=1 for exactly this one cycle -> WAIT_CONV.
//  - WAIT_CONV: conv_done=1 -> WRITE. conv_done outside WAIT_CONV is ignored.
//  - WRITE: reg_we=1 for exactly this one cycle -> IDLE.
//  - Latency, hex path: tick at cycle t, adc_req high from t+1, adc_valid at t+1 -> reg_we at t+2.
//  - Latency, BCD path: adc_valid at t+1, conv_start at t+2, conv_done at t+k -> reg_we at t+k+1.
//  - Timeout: wait counter clears on entry to REQ_ADC and WAIT_CONV, increments each waiting cycle.
//    When it reaches TIMEOUT: set timeout_err, go to IDLE, no reg_we (display keeps old value).
//  - Tick while busy: dropped; no queuing; prescaler keeps running.
//  - hold_toggle: flips hold in any state. An in-flight cycle always completes, including its
//    reg_we. New cycles start only when hold=0.
//  - enable=0: prescaler holds its value; an in-flight cycle completes normally.
//  - tick and hold_toggle in the same cycle in IDLE: the toggled value of hold decides, so a
//    hold 0->1 toggle suppresses the cycle.
//  - Outputs are registered (Moore, decoded from registered state); no combinational path from
//    inputs to outputs.
// STRUCTURE
//  - Package meas_sched_pkg:
//    - typedef enum logic [2:0] sched_state_t {IDLE, REQ_ADC, START_CONV, WAIT_CONV, WRITE}
//    - localparam MODE_BCD_BIT = 1
//  - Sub-module tick_generator #(DIV): prescaler with enable and 1-cycle tick output.
//  - FSM, wait counter, hold flop and sticky error live in this module.
// TESTING  (TICK_DIV=8, TIMEOUT=15)
//  1. mode=2'b00, adc_valid tied 1 -> reg_we every 8 cycles, 2 cycles after tick; conv_start never 1.
//  2. mode=2'b10, conv_done 5 cycles after conv_start -> conv_start once, reg_we 1 cycle after
//     conv_done; busy high throughout the cycle.
//  3. adc_valid held 0 -> adc_req high 15 cycles, then timeout_err=1, FSM IDLE, no reg_we;
//     next tick starts a fresh cycle.
//  4. hold_toggle during WAIT_CONV -> current reg_we still issued, hold=1, no further adc_req;
//     second toggle -> refresh resumes on the next tick.
//  5. reset_n low mid-WAIT_CONV -> all outputs 0 asynchronously, timeout_err cleared; after release,
//     first reg_we follows the first tick.
//  6. mode changed 2'b10->2'b00 in REQ_ADC -> BCD path still taken for that cycle; hex path on next.

Source files
------------

// File: rtl/measurement_scheduler_pkg.sv
// Shared types and constants for the measurement scheduler.
package meas_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ADC,
    START_CONV,
    WAIT_CONV,
    WRITE
  } sched_state_t;

  // Bit of the mode switch that selects the BCD path (1) over the hex path (0).
  localparam int unsigned MODE_BCD_BIT = 1;

  // True when the given mode word requests the BCD conversion path.
  function automatic logic mode_is_bcd(input logic [1:0] mode);
    return mode[MODE_BCD_BIT];
  endfunction

endpackage

// File: rtl/measurement_scheduler_if.sv
// Handshake bundle between the scheduler and the ADC / binary_bcd / display datapath.
interface measurement_scheduler_if;

  logic       enable;
  logic       hold_toggle;
  logic [1:0] mode;
  logic       adc_valid;
  logic       conv_done;
  logic       adc_req;
  logic       conv_start;
  logic       reg_we;
  logic       hold;
  logic       busy;
  logic       timeout_err;

  // Scheduler side.
  modport slave (
    input  enable, hold_toggle, mode, adc_valid, conv_done,
    output adc_req, conv_start, reg_we, hold, busy, timeout_err
  );

  // Environment side (datapath, debouncer, switches).
  modport master (
    output enable, hold_toggle, mode, adc_valid, conv_done,
    input  adc_req, conv_start, reg_we, hold, busy, timeout_err
  );

endinterface

// File: rtl/measurement_scheduler_tick_generator.sv
// Refresh prescaler: counts 0..DIV-1 while enabled and emits a one-cycle tick on the last count.
module tick_generator #(
  parameter int unsigned DIV = 5_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned    W    = $clog2(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] count_q, count_d;

  // Advance (and wrap) only while enabled; otherwise the count is frozen.
  always_comb begin
    count_d = count_q;
    if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Gated by enable so a frozen count at LAST does not produce a stuck tick.
  assign tick_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/measurement_scheduler.sv
// Measurement/display sequencer: per refresh tick, request an ADC sample, optionally run the
// BCD conversion, then pulse the display register write enable. Button toggles HOLD.
module measurement_scheduler
  import meas_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                    clk,
  input  logic                    reset_n,
  measurement_scheduler_if.slave  sif
);

  localparam int unsigned  WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  sched_state_t  state_q, state_d;
  logic [WW-1:0] wait_q,  wait_d;
  logic          bcd_q,   bcd_d;
  logic          hold_q,  hold_d;
  logic          err_q,   err_d;
  logic          tick;

  tick_generator #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable_i (sif.enable),
    .tick_o   (tick)
  );

  // Next-state logic: FSM, handshake wait counter, path latch, hold flop and sticky error.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    // The toggled hold value is what gates a tick arriving in the same cycle.
    hold_d  = hold_q ^ sif.hold_toggle;

    unique case (state_q)
      IDLE: begin
        if (tick && !hold_d) begin
          state_d = REQ_ADC;
          bcd_d   = mode_is_bcd(sif.mode);
          wait_d  = '0;
        end
      end
      REQ_ADC: begin
        if (sif.adc_valid) begin
          state_d = bcd_q ? START_CONV : WRITE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      START_CONV: begin
        state_d = WAIT_CONV;
        wait_d  = '0;
      end
      WAIT_CONV: begin
        if (sif.conv_done) begin
          state_d = WRITE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      bcd_q   <= 1'b0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bcd_q   <= bcd_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs decoded purely from registered state.
  assign sif.adc_req     = (state_q == REQ_ADC);
  assign sif.conv_start  = (state_q == START_CONV);
  assign sif.reg_we      = (state_q == WRITE);
  assign sif.busy        = (state_q != IDLE);
  assign sif.hold        = hold_q;
  assign sif.timeout_err = err_q;

endmodule
